// File: rtl/sys_pkg.sv
// Shared types and constants for the systolic array feeder.
package sys_pkg;

    localparam int K_LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        DONE
    } feeder_state_t;

    // Advancing cycles needed to push the deepest lane's last element out.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Memory-reader stream in, skewed array edges out.
interface systolic_feeder_if #(
    parameter int Data_Width = 8,
    parameter int N          = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*Data_Width-1:0] in_left;
    logic [N*Data_Width-1:0] in_top;
    logic [N*Data_Width-1:0] arr_left;
    logic [N*Data_Width-1:0] arr_top;
    logic                    arr_waitrequest;
    logic                    arr_clear;

    modport master (
        output in_valid, in_left, in_top,
        input  in_ready, arr_left, arr_top, arr_waitrequest, arr_clear
    );

    modport slave (
        input  in_valid, in_left, in_top,
        output in_ready, arr_left, arr_top, arr_waitrequest, arr_clear
    );
endinterface

// File: rtl/skew_delay_line.sv
// Enable-gated shift register; one lane of the diagonal skew.
module skew_delay_line #(
    parameter int Data_Width = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [Data_Width-1:0] d,
    output logic [Data_Width-1:0] q
);
    logic signed [Data_Width-1:0] sr_p [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) sr_p[k] <= '0;
        end else if (en) begin
            sr_p[0] <= d;
            for (int k = 1; k < DEPTH; k++) sr_p[k] <= sr_p[k-1];
        end
    end

    assign q = sr_p[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// Skewing feeder for an N x N systolic MAC array: tile FSM, stall/clear
// generation and one delay line per edge lane (lane i delayed i steps).
module systolic_feeder
    import sys_pkg::*;
#(
    parameter int Data_Width = 8,
    parameter int N          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_LEN_W-1:0] k_len,
    output logic               busy,
    output logic               done,
    systolic_feeder_if.slave   bus
);
    localparam int FLUSH_LEN = flush_len(N);
    localparam int FCNT_W    = $clog2(FLUSH_LEN + 1);

    feeder_state_t      state;
    logic [K_LEN_W-1:0] k_len_q;
    logic [K_LEN_W-1:0] acc_cnt;
    logic [FCNT_W-1:0]  flush_cnt;
    logic               waitreq_q;
    logic               clear_q;
    logic               run_ready;
    logic               accept;
    logic               advance;

    // Ready depends only on state and count so the reader never sees a loop.
    assign run_ready = (state == RUN) && (acc_cnt < k_len_q);
    assign accept    = bus.in_valid & run_ready;
    assign advance   = accept | (state == FLUSH);

    assign bus.in_ready        = run_ready;
    assign bus.arr_waitrequest = waitreq_q;
    assign bus.arr_clear       = clear_q;
    assign busy                = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_len_q   <= '0;
            acc_cnt   <= '0;
            flush_cnt <= '0;
            waitreq_q <= 1'b1;
            clear_q   <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Stall flag moves on the same edge as the data it qualifies.
            waitreq_q <= ~advance;
            clear_q   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_len_q <= k_len;
                        acc_cnt <= '0;
                        clear_q <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (k_len_q == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + K_LEN_W'(1);
                        if ((acc_cnt + K_LEN_W'(1)) == k_len_q) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FCNT_W'(FLUSH_LEN - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FCNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 of every lane: live data in RUN, zeros while flushing.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [Data_Width-1:0] left_p0;
        logic [Data_Width-1:0] top_p0;
        logic [Data_Width-1:0] left_q;
        logic [Data_Width-1:0] top_q;

        assign left_p0 = (state == RUN) ? bus.in_left[i*Data_Width +: Data_Width] : '0;
        assign top_p0  = (state == RUN) ? bus.in_top[i*Data_Width +: Data_Width]  : '0;

        skew_delay_line #(.Data_Width(Data_Width), .DEPTH(i + 1)) u_left (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .d   (left_p0),
            .q   (left_q)
        );

        skew_delay_line #(.Data_Width(Data_Width), .DEPTH(i + 1)) u_top (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .d   (top_p0),
            .q   (top_q)
        );

        assign bus.arr_left[i*Data_Width +: Data_Width] = left_q;
        assign bus.arr_top[i*Data_Width +: Data_Width]  = top_q;
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: cycle scoreboard from a step-level model, plus a
// behavioural 4x4 MAC array fed by the DUT edges.
module tb_systolic_feeder;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int W  = N * DW;
    localparam int FL = 2 * N - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] k_len;
    logic        busy;
    logic        done;

    systolic_feeder_if #(.Data_Width(DW), .N(N)) bus ();

    systolic_feeder #(.Data_Width(DW), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k_len (k_len),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic         clr;
        logic         dn;
        logic         bz;
        logic [W-1:0] l;
        logic [W-1:0] t;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t last;

    // Model state: 0 idle, 1 clear, 2 run, 3 flush, 4 done
    int           ms, mcnt, mk, mfl, madv;
    logic [W-1:0] vl[$];
    logic [W-1:0] vt[$];

    int acc[N][N];
    int ar[N][N];
    int br[N][N];

    always @(posedge clk) begin
        if (bus.arr_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= 0; ar[i][j] <= 0; br[i][j] <= 0;
                end
        end else if (!bus.arr_waitrequest) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] +
                        ((j == 0) ? int'($signed(bus.arr_left[i*DW +: DW])) : ar[i][(j == 0) ? 0 : j-1]) *
                        ((i == 0) ? int'($signed(bus.arr_top[j*DW +: DW]))  : br[(i == 0) ? 0 : i-1][j]);
                    ar[i][j] <= (j == 0) ? int'($signed(bus.arr_left[i*DW +: DW])) : ar[i][(j == 0) ? 0 : j-1];
                    br[i][j] <= (i == 0) ? int'($signed(bus.arr_top[j*DW +: DW]))  : br[(i == 0) ? 0 : i-1][j];
                end
        end
    end

    function automatic logic m_ready();
        return (ms == 2) && (mcnt < mk);
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.wr  = bus.arr_waitrequest;
        o.clr = bus.arr_clear;
        o.dn  = done;
        o.bz  = busy;
        o.l   = bus.arr_left;
        o.t   = bus.arr_top;
        return o;
    endfunction

    task automatic model_reset();
        ms = 0; mcnt = 0; mk = 0; mfl = 0; madv = 0;
        vl.delete(); vt.delete(); exp_q.delete();
        last = '0;
        last.wr = 1'b1;
    endtask

    // Predict the state after the coming edge, push it, then step the clock.
    task automatic tick();
        exp_t         e;
        logic         adv;
        int           m;
        logic [W-1:0] tmp;
        adv = ((ms == 2) && bus.in_valid && m_ready()) || (ms == 3);
        e = last;
        e.clr = (ms == 0) && start;
        e.dn  = 1'b0;
        e.wr  = !adv;
        if (adv) begin
            if (ms == 2) begin
                vl.push_back(bus.in_left);
                vt.push_back(bus.in_top);
            end
            m = madv;
            madv++;
            for (int i = 0; i < N; i++) begin
                if ((m - i) >= 0 && (m - i) < vl.size()) begin
                    tmp = vl[m-i]; e.l[i*DW +: DW] = tmp[i*DW +: DW];
                    tmp = vt[m-i]; e.t[i*DW +: DW] = tmp[i*DW +: DW];
                end else begin
                    e.l[i*DW +: DW] = '0;
                    e.t[i*DW +: DW] = '0;
                end
            end
        end
        case (ms)
            0: if (start) begin
                   mk = int'(k_len); mcnt = 0; madv = 0;
                   vl.delete(); vt.delete(); ms = 1;
               end
            1: begin
                   if (mk == 0) begin ms = 4; e.dn = 1'b1; end
                   else ms = 2;
               end
            2: if (adv) begin
                   mcnt++;
                   if (mcnt == mk) begin ms = 3; mfl = 0; end
               end
            3: begin
                   mfl++;
                   if (mfl == FL) begin ms = 4; e.dn = 1'b1; end
               end
            default: ms = 0;
        endcase
        e.bz = (ms != 0);
        last = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        exp_t o;
        exp_t e;
        rst = 1'b1; start = 1'b0; k_len = '0;
        bus.in_valid = 1'b0; bus.in_left = '0; bus.in_top = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready: got %b want 0", bus.in_ready);
            end
            tick();
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL reset_idle c%0d: got %h want %h", c, o, e);
            end
            checks++;
            if (bus.arr_waitrequest !== 1'b1 || busy !== 1'b0 || bus.arr_left !== '0 || bus.arr_top !== '0) begin
                errors++;
                $display("FAIL reset_values: got wr=%b busy=%b left=%h top=%h want wr=1 busy=0 left=0 top=0",
                         bus.arr_waitrequest, busy, bus.arr_left, bus.arr_top);
            end
        end
    endtask

    task automatic test_single();
        exp_t o;
        exp_t e;
        int   s, done_cyc, clr_cyc;
        s = cyc; done_cyc = -1; clr_cyc = -1;
        start = 1'b1; k_len = 16'd1; bus.in_valid = 1'b1;
        bus.in_left = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.in_top  = {8'd8, 8'd7, 8'd6, 8'd5};
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (bus.in_ready !== m_ready()) begin
                errors++; $display("FAIL single_ready c%0d: got %b want %b", c, bus.in_ready, m_ready());
            end
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL single_sb c%0d: got %h want %h", c, o, e);
            end
            if (done === 1'b1) done_cyc = cyc;
            if (bus.arr_clear === 1'b1) clr_cyc = cyc;
            for (int i = 0; i < N; i++)
                if (cyc == s + 3 + i) begin
                    checks++;
                    if (bus.arr_left[i*DW +: DW] !== 8'(i + 1) || bus.arr_waitrequest !== 1'b0) begin
                        errors++;
                        $display("FAIL single_lane%0d: got %0d wr=%b want %0d wr=0",
                                 i, bus.arr_left[i*DW +: DW], bus.arr_waitrequest, i + 1);
                    end
                end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (clr_cyc != s + 1) begin
            errors++; $display("FAIL single_clear_time: got %0d want %0d", clr_cyc - s, 1);
        end
        checks++;
        if (done_cyc != s + 10) begin
            errors++; $display("FAIL single_done_time: got %0d want %0d", done_cyc - s, 10);
        end
    endtask

    task automatic test_stall();
        exp_t o;
        exp_t e;
        int   s, done_cyc, stalls;
        s = cyc; done_cyc = -1; stalls = 0;
        start = 1'b1; k_len = 16'd3;
        for (int c = 0; c < 17; c++) begin
            bus.in_valid = (c == 2) || (c == 5) || (c == 6);
            bus.in_left  = {8'(c + 40), 8'(c + 30), 8'(c + 20), 8'(c + 10)};
            bus.in_top   = {8'(c + 90), 8'(c + 80), 8'(c + 70), 8'(c + 60)};
            checks++;
            if (bus.in_ready !== m_ready()) begin
                errors++; $display("FAIL stall_ready c%0d: got %b want %b", c, bus.in_ready, m_ready());
            end
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL stall_sb c%0d: got %h want %h", c, o, e);
            end
            if (done === 1'b1) done_cyc = cyc;
            if (cyc >= s + 3 && cyc <= s + 13 && bus.arr_waitrequest === 1'b1) stalls++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (stalls != 2) begin
            errors++; $display("FAIL stall_count: got %0d want 2", stalls);
        end
        checks++;
        if (done_cyc != s + 14) begin
            errors++; $display("FAIL stall_done_time: got %0d want %0d", done_cyc - s, 14);
        end
    endtask

    task automatic test_signed();
        exp_t         o;
        exp_t         e;
        int           a[4][4];
        int           gold;
        logic [W-1:0] tl, tt;
        a[0] = '{-128, 127, -1, 0};
        a[1] = '{5, -6, 7, -8};
        a[2] = '{100, -100, 50, -50};
        a[3] = '{-1, -2, -3, -4};
        start = 1'b1; k_len = 16'd4;
        for (int c = 0; c < 15; c++) begin
            bus.in_valid = (c >= 2) && (c <= 5);
            tl = '0; tt = '0;
            if (c >= 2 && c <= 5)
                for (int i = 0; i < N; i++) begin
                    tl[i*DW +: DW] = 8'(a[c-2][i]);
                    tt[i*DW +: DW] = (i == c - 2) ? 8'd1 : 8'd0;
                end
            bus.in_left = tl;
            bus.in_top  = tt;
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL signed_sb c%0d: got %h want %h", c, o, e);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                gold = 0;
                for (int t = 0; t < 4; t++) gold += a[t][i] * ((t == j) ? 1 : 0);
                checks++;
                if (acc[i][j] !== gold) begin
                    errors++; $display("FAIL signed_mac[%0d][%0d]: got %0d want %0d", i, j, acc[i][j], gold);
                end
            end
    endtask

    task automatic test_kzero();
        exp_t o;
        exp_t e;
        int   s, done_cyc, ready_seen, wr_low;
        s = cyc; done_cyc = -1; ready_seen = 0; wr_low = 0;
        start = 1'b1; k_len = 16'd0; bus.in_valid = 1'b1;
        bus.in_left = 32'h11223344; bus.in_top = 32'h55667788;
        for (int c = 0; c < 6; c++) begin
            if (bus.in_ready === 1'b1) ready_seen++;
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL kzero_sb c%0d: got %h want %h", c, o, e);
            end
            if (done === 1'b1) done_cyc = cyc;
            if (bus.arr_waitrequest !== 1'b1) wr_low++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done_cyc != s + 2) begin
            errors++; $display("FAIL kzero_done_time: got %0d want 2", done_cyc - s);
        end
        checks++;
        if (ready_seen != 0 || wr_low != 0) begin
            errors++; $display("FAIL kzero_no_accept: got ready=%0d wr_low=%0d want 0 0", ready_seen, wr_low);
        end
    endtask

    task automatic test_reset_mid();
        exp_t o;
        exp_t e;
        int   s, done_cyc;
        start = 1'b1; k_len = 16'd5; bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.in_left = {8'(c + 4), 8'(c + 3), 8'(c + 2), 8'(c + 1)};
            bus.in_top  = {8'(c + 8), 8'(c + 7), 8'(c + 6), 8'(c + 5)};
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL rstmid_pre c%0d: got %h want %h", c, o, e);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.arr_left !== '0 || bus.arr_top !== '0 || bus.arr_waitrequest !== 1'b1 ||
            bus.arr_clear !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got left=%h top=%h wr=%b clr=%b done=%b busy=%b rdy=%b want 0 0 1 0 0 0 0",
                     bus.arr_left, bus.arr_top, bus.arr_waitrequest, bus.arr_clear, done, busy, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        s = cyc; done_cyc = -1;
        start = 1'b1; k_len = 16'd2; bus.in_valid = 1'b1;
        for (int c = 0; c < 13; c++) begin
            bus.in_left = {8'(c * 3), 8'(c * 5), 8'(c * 7), 8'(c + 100)};
            bus.in_top  = {8'(c + 200), 8'(c * 2), 8'(c + 50), 8'(c * 9)};
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL rstmid_post c%0d: got %h want %h", c, o, e);
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done_cyc != s + 11) begin
            errors++; $display("FAIL rstmid_done_time: got %0d want 11", done_cyc - s);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_signed();
        test_kzero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Skewing input feeder for the N×N systolic MAC array. It accepts one N-wide A-row vector and one N-wide B-column vector per step from the memory-reader stream. It drives the array's left and top edges with the diagonal skew the PEs require: lane i is delayed i steps. It also generates the array's stall (`waitrequest`) and accumulator-clear pulses, so the array sees only aligned data or a held bubble.

## Interface
- `Data_Width`, 8 — signed element width; matches the PE data width.
- `N`, 4 — array dimension (lanes per edge); N ≥ 2.
- `clk`  in  1  — single clock; all logic on posedge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `start`  in  1  — begin a tile; sampled only in IDLE.
- `k_len`  in  16  — vectors per tile; sampled with `start`.
- `in_valid`  in  1  — input vector pair valid.
- `in_ready`  out  1  — feeder accepts this cycle.
- `in_left`  in  N*Data_Width  — A-row elements; lane i = bits [i*DW +: DW].
- `in_top`  in  N*Data_Width  — B-column elements, same packing.
- `arr_left`  out  N*Data_Width  — to the array's left-edge inputs (row i).
- `arr_top`  out  N*Data_Width  — to the array's top-edge inputs (column j).
- `arr_waitrequest`  out  1  — array stall; PEs hold and add zero.
- `arr_clear`  out  1  — one-cycle accumulator clear to the array reset input.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse when the tile is fully drained.

## Operation
- States: IDLE → CLEAR → RUN → FLUSH → DONE → IDLE.
- IDLE:
  - `start` with any `k_len` → CLEAR.
  - `start` while busy is ignored.
- CLEAR: lasts 1 cycle. `arr_clear`=1 registered during this cycle; data lines are zeroed.
  - `k_len`=0 → DONE.
  - Otherwise → RUN.
- RUN:
  - `in_ready`=1 while accepted count < `k_len`; `in_ready` is combinational from state and counter only, never from `in_valid`.
  - Accept = `in_valid & in_ready`. On accept, lane i of each edge loads its delay line stage 0 and all lines advance one step.
  - No accept → every delay line holds.
  - Counter reaches `k_len` → FLUSH.
- FLUSH: exactly 2N−1 advancing cycles with zero injected at stage 0 of every lane, then → DONE.
- DONE: `done`=1 for 1 cycle → IDLE.
- Delay lines: lane i has i+1 registers; the last register drives the output lane. Data passes through unmodified (no sign handling, no arithmetic).
- `arr_waitrequest` is registered and updated on the same edge as the data registers:
  - Next value = 0 if the cycle advanced (RUN accept or FLUSH).
  - Next value = 1 otherwise (IDLE, CLEAR, DONE, RUN without accept).
- Because data and `waitrequest` update on the same edge, a held data value is never accumulated twice.
- Reset mid-operation: state → IDLE, counter and all delay lines → 0, no `done`, no `arr_clear`.

## Timing
- Reset values:
  - 1: `arr_waitrequest`.
  - 0: `arr_left`, `arr_top`, `arr_clear`, `busy`, `done`, `in_ready`.
- `start` at cycle s:
  - `arr_clear` is high in cycle s+1.
  - RUN begins at s+2, so the first possible accept is at s+2.
- Vector accepted at cycle c with no later stalls: lane i element appears on the output in cycle c+1+i, with `arr_waitrequest`=0 in that cycle.
- Each stall cycle adds one cycle to all pending lanes.
- Last accept at cycle L, no stalls: FLUSH occupies L+1..L+2N−1, `done` is at L+2N, and IDLE is at L+2N+1.
- `in_valid` may drop at any time without penalty beyond the stall cycles. Nothing is accepted outside RUN.

## Structure
- Shared package `sys_pkg`:
  - state enum `feeder_state_t` (IDLE, CLEAR, RUN, FLUSH, DONE);
  - `function flush_len(N) = 2*N-1`;
  - `K_LEN_W = 16`.
- Sub-module `skew_delay_line` (parameters `Data_Width`, `DEPTH`; ports clk, rst, en, d, q).
  - Instantiated 2N times with DEPTH = i+1.
  - `en` is the shared advance signal.
- The top level holds the FSM, the accept counter, the flush counter and the registered `arr_waitrequest`/`arr_clear`/`done`.

## Test plan
- Reset, then idle 5 cycles → `arr_waitrequest`=1, all data outputs 0, `busy`=0, `in_ready`=0.
- N=4, `k_len`=1, `in_left` lanes = {1,2,3,4}, `in_valid` held high → `arr_clear` at s+1; accept at s+2; left lane i = i+1 at cycle s+3+i; `done` at s+10.
- N=4, `k_len`=3 with `in_valid` low for 2 cycles between vectors 1 and 2 → exactly 2 extra cycles with `arr_waitrequest`=1; outputs held; `done` delayed by 2.
- Signed data: lanes = {-128, 127, -1, 0} → the same bit patterns emerge, skewed; behind a 4×4 array of `SYSMAC` PEs, the products against B = identity match a golden model.
- `k_len`=0 → CLEAR then `done` at s+2; no accept; `arr_waitrequest` stays 1.
- `rst` asserted mid-RUN (after 2 of 5 accepts) → outputs 0 immediately (async); IDLE; a new `start` runs a full tile correctly.
